frv_mem_responder: RTL and testbench

Word-addressed memory model that answers the core's `imem_*` / `dmem_*` request interface: chip enable, write enable, strobe, address and write data in; read data, stall and error out. It sits on the far side of the CPU's instruction or data port in simulation benches and FPGA builds. One instance serves one port. It provides configurable wait states, byte-strobed writes, and range and alignment error signalling.

---
 rtl/frv_mem_pkg.sv | 22 ++
 rtl/frv_mem_sram_array.sv | 40 ++++
 rtl/frv_mem_responder.sv | 94 +++++++++
 tb/tb_frv_mem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/frv_mem_pkg.sv
// Shared constants and the address-check helper for frv_mem_responder.
package frv_mem_pkg;

    localparam int         CNT_W     = 4;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Fibonacci taps 8,6,5,4 map to bits 7,5,4,3 of the shift register.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Range check is done in 33 bits so BASE + size never wraps.
    function automatic logic addr_error(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [32:0] size_bytes);
        logic [32:0] a33;
        logic [32:0] lo;
        logic [32:0] hi;
        a33 = {1'b0, addr};
        lo  = {1'b0, base};
        hi  = lo + size_bytes;
        return (a33 < lo) || (a33 >= hi) || (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/frv_mem_sram_array.sv
// Word array with byte-enabled synchronous write and a registered read port.
module frv_mem_sram_array #(
    parameter int MEM_DEPTH = 1024,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic             clr,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register holds until the next read; clr loads zero for a faulting read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/frv_mem_responder.sv
// Memory responder for the imem_/dmem_ port with wait states and error signalling.
// Optional FRV_MEM_RESPONDER_RANDOM_STALL_EN adds LFSR-driven extra stalls.
module frv_mem_responder
    import frv_mem_pkg::*;
#(
    parameter int          MEM_DEPTH   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        mem_cen,
    input  logic        mem_wen,
    input  logic [3:0]  mem_strb,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_stall,
    output logic        mem_error,
    output logic [31:0] mem_rdata
);

    localparam int               IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [CNT_W-1:0] WAIT_VAL   = CNT_W'(WAIT_CYCLES);
    localparam logic [32:0]      SIZE_BYTES = 33'(MEM_DEPTH) << 2;

    logic [CNT_W-1:0] cnt;
    logic             wait_stall;
    logic             rand_stall;
    logic             accept_p0;
    logic             err_p0;
    logic [IDX_W-1:0] idx_p0;
    logic             error_p1;

    assign wait_stall = mem_cen && (cnt != WAIT_VAL);

`ifdef FRV_MEM_RESPONDER_RANDOM_STALL_EN
    logic [7:0] lfsr;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign rand_stall = mem_cen && lfsr[0];
`else
    assign rand_stall = 1'b0;
`endif

    assign mem_stall = wait_stall || rand_stall;
    assign accept_p0 = mem_cen && !mem_stall;
    assign err_p0    = addr_error(mem_addr, BASE_ADDR, SIZE_BYTES);
    assign idx_p0    = IDX_W'((mem_addr - BASE_ADDR) >> 2);

    // The counter parks at WAIT_CYCLES while only the random stall is holding off acceptance.
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            cnt <= '0;
        end else if (!mem_cen || accept_p0) begin
            cnt <= '0;
        end else if (wait_stall) begin
            cnt <= cnt + 1'b1;
        end
    end

    // ---- p0 accept edge -> p1 response ----
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            error_p1 <= 1'b0;
        end else begin
            error_p1 <= accept_p0 && err_p0;
        end
    end

    frv_mem_sram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk   (g_clk),
        .rst   (g_reset),
        .we    (accept_p0 && mem_wen && !err_p0),
        .re    (accept_p0 && !mem_wen && !err_p0),
        .clr   (accept_p0 && !mem_wen && err_p0),
        .be    (mem_strb),
        .idx   (idx_p0),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    assign mem_error = error_p1;

endmodule

// File: tb/tb_frv_mem_responder.sv
// Randomized bench for frv_mem_responder: three instances (wait 0, 3, 2) against a word-array model.
module tb_frv_mem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cen   [3];
    logic        wen   [3];
    logic [3:0]  strb  [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        stall [3];
    logic        err   [3];
    logic [31:0] rdata [3];

    logic [31:0] model [3][DEPTH];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        frv_mem_responder #(
            .MEM_DEPTH   (DEPTH),
            .BASE_ADDR   (BASE),
            .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 3 : 2))
        ) u_dut (
            .g_clk     (clk),
            .g_reset   (rst),
            .mem_cen   (cen[g]),
            .mem_wen   (wen[g]),
            .mem_strb  (strb[g]),
            .mem_addr  (addr[g]),
            .mem_wdata (wdata[g]),
            .mem_stall (stall[g]),
            .mem_error (err[g]),
            .mem_rdata (rdata[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int wait_of(input int u);
        return (u == 0) ? 0 : ((u == 1) ? 3 : 2);
    endfunction

    function automatic bit ref_err(input logic [31:0] a);
        longint la;
        la = a;
        return (la < longint'(BASE)) || (la >= longint'(BASE) + DEPTH * 4) || ((a % 4) != 0);
    endfunction

    // Wait (bounded) for stall to drop, then pass the accepting edge.
    task automatic accept_edge(input int u, output int stalls);
        stalls = 0;
        #1;
        while (stall[u] === 1'b1 && stalls < 64) begin
            stalls++;
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        if (stalls >= 64) check_eq("stall_timeout", 32'd1, 32'd0);
        @(posedge clk);
    endtask

    task automatic do_req(input int u, input bit w, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] got_rdata, output logic got_err);
        int          stalls;
        bit          e;
        int          wi;
        logic [31:0] prev;
        logic [31:0] exp_rd;
        e    = ref_err(a);
        wi   = e ? 0 : int'((a - BASE) >> 2);
        prev = rdata[u];
        cen[u] = 1'b1; wen[u] = w; strb[u] = s; addr[u] = a; wdata[u] = d;
        accept_edge(u, stalls);
        @(negedge clk);
        cen[u] = 1'b0;
        got_rdata = rdata[u];
        got_err   = err[u];
`ifdef FRV_MEM_RESPONDER_RANDOM_STALL_EN
        check_eq("stall_min", 32'(stalls >= wait_of(u)), 32'd1);
`else
        check_eq("stall_cnt", stalls, wait_of(u));
`endif
        check_eq("error", got_err, e);
        if (w) begin
            check_eq("rdata_hold", got_rdata, prev);
            if (!e) begin
                for (int i = 0; i < 4; i++) begin
                    if (s[i]) model[u][wi][8*i +: 8] = d[8*i +: 8];
                end
            end
        end else begin
            exp_rd = e ? 32'h0 : model[u][wi];
            check_eq("rdata", got_rdata, exp_rd);
        end
    endtask

    function automatic logic [31:0] pick_addr();
        int k;
        int w;
        k = $urandom_range(0, 11);
        w = $urandom_range(0, 16);
        if (w == 16) w = DEPTH - 1;
        case (k)
            0: return BASE - 32'd4;
            1: return BASE + DEPTH * 4;
            2: return BASE + w * 4 + $urandom_range(1, 3);
            3: return 32'hFFFF_FFFC;
            4: return 32'h0000_0000;
            default: return BASE + w * 4;
        endcase
    endfunction

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          st;

        for (int u = 0; u < 3; u++) begin
            cen[u] = 1'b0; wen[u] = 1'b0; strb[u] = 4'h0; addr[u] = BASE; wdata[u] = 32'h0;
        end
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check_eq("rst_rdata", rdata[u], 32'h0);
            check_eq("rst_error", err[u], 1'b0);
            check_eq("rst_stall", stall[u], 1'b0);
        end
        rst = 1'b0;

        // Full write then read, then a single-byte strobed update.
        do_req(0, 1'b1, 4'hF, 32'h8000_0010, 32'hDEADBEEF, r, e);
        do_req(0, 1'b0, 4'h0, 32'h8000_0010, 32'h0, r, e);
        check_eq("t1_rd", r, 32'hDEADBEEF);
        do_req(0, 1'b1, 4'b0010, 32'h8000_0010, 32'h0000_5500, r, e);
        do_req(0, 1'b0, 4'h0, 32'h8000_0010, 32'h0, r, e);
        check_eq("t1_rd_strb", r, 32'hDEAD55EF);
        do_req(0, 1'b1, 4'h0, 32'h8000_0010, 32'hFFFF_FFFF, r, e);
        do_req(0, 1'b0, 4'h0, 32'h8000_0010, 32'h0, r, e);
        check_eq("strb0_keep", r, 32'hDEAD55EF);

        // Range and alignment faults.
        do_req(0, 1'b1, 4'hF, 32'h8000_0000, 32'h1122_3344, r, e);
        do_req(0, 1'b0, 4'h0, 32'h7FFF_FFFC, 32'h0, r, e);
        check_eq("oob_lo_err", e, 1'b1);
        do_req(0, 1'b0, 4'h0, 32'h8000_1000, 32'h0, r, e);
        check_eq("oob_hi_err", e, 1'b1);
        do_req(0, 1'b0, 4'h0, 32'h8000_0002, 32'h0, r, e);
        check_eq("misalign_err", e, 1'b1);
        check_eq("misalign_rd", r, 32'h0);
        @(negedge clk);
        check_eq("err_pulse", err[0], 1'b0);
        do_req(0, 1'b1, 4'hF, 32'h8000_1000, 32'hFFFF_FFFF, r, e);
        do_req(0, 1'b0, 4'h0, 32'h8000_0000, 32'h0, r, e);
        check_eq("oob_wr_keep", r, 32'h1122_3344);

        // Three wait states.
        do_req(1, 1'b1, 4'hF, 32'h8000_0020, 32'hCAFE_F00D, r, e);
        do_req(1, 1'b0, 4'h0, 32'h8000_0020, 32'h0, r, e);
        check_eq("w3_rd", r, 32'hCAFE_F00D);

        // Abandoned request restarts its wait.
        do_req(2, 1'b1, 4'hF, 32'h8000_0030, 32'h0BAD_F00D, r, e);
        cen[2] = 1'b1; wen[2] = 1'b0; strb[2] = 4'h0; addr[2] = 32'h8000_0030;
        #1;
`ifndef FRV_MEM_RESPONDER_RANDOM_STALL_EN
        check_eq("abandon_stall0", stall[2], 1'b1);
`endif
        @(posedge clk);
        @(negedge clk);
        #1;
`ifndef FRV_MEM_RESPONDER_RANDOM_STALL_EN
        check_eq("abandon_stall1", stall[2], 1'b1);
`endif
        cen[2] = 1'b0;
        #1;
        check_eq("abandon_idle", stall[2], 1'b0);
        @(posedge clk);
        @(negedge clk);
        do_req(2, 1'b0, 4'h0, 32'h8000_0030, 32'h0, r, e);
        check_eq("abandon_rd", r, 32'h0BAD_F00D);

        // Reset right after a read accept clears the response asynchronously.
        cen[0] = 1'b1; wen[0] = 1'b0; addr[0] = 32'h8000_0010;
        accept_edge(0, st);
        #1 cen[0] = 1'b0;
        check_eq("pre_rst_rd", rdata[0], 32'hDEAD55EF);
        rst = 1'b1;
        #1;
        check_eq("async_rst_rd", rdata[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cen[0] = 1'b1; wen[0] = 1'b0; addr[0] = BASE - 32'd4;
        accept_edge(0, st);
        #1 cen[0] = 1'b0;
        check_eq("pre_rst_err", err[0], 1'b1);
        rst = 1'b1;
        #1;
        check_eq("async_rst_err", err[0], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        do_req(0, 1'b0, 4'h0, 32'h8000_0010, 32'h0, r, e);
        check_eq("post_rst_rd", r, 32'hDEAD55EF);

        // Random traffic on every instance over a small working set plus fault addresses.
        for (int u = 0; u < 3; u++) begin
            for (int w = 0; w <= 16; w++) begin
                do_req(u, 1'b1, 4'hF, BASE + ((w == 16) ? DEPTH - 1 : w) * 4, $urandom, r, e);
            end
            for (int n = 0; n < 350; n++) begin
                do_req(u, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), pick_addr(), $urandom, r, e);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
